// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the telemetry UART transmitter.
package telemetry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SYNC1,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } tx_state_t;

  localparam logic [7:0] SYNC0_DEF  = 8'hAA;
  localparam logic [7:0] SYNC1_DEF  = 8'h55;

  // start + 8 data + stop
  localparam int         FRAME_BITS = 10;

  // Bit period in clocks, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/telemetry_tx_uart.sv
// Single-byte 8N1 serialiser. The line is driven from a register one cycle
// behind the shift register, so a byte loaded in the last cycle of the
// previous stop bit follows it on TxD with no idle gap.
module uart_tx_byte
  import telemetry_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       load,
  output logic       TxD,
  output logic       ready,
  output logic       byte_done
);

  localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  BIT_TC = CW'(DIV - 1);
  localparam logic [3:0]     LAST_BIT = 4'(FRAME_BITS - 1);

  logic                active;
  logic [9:0]          shreg;
  logic [3:0]          bit_cnt;
  logic [CW-1:0]       baud_cnt;

  // Last clock of the stop bit: a new byte may be loaded here seamlessly.
  assign byte_done = active && (bit_cnt == LAST_BIT) && (baud_cnt == '0);
  assign ready     = !active || byte_done;

  // Baud down-counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      TxD      <= 1'b1;
    end else begin
      TxD <= shreg[0];
      if (load && ready) begin
        shreg    <= {1'b1, data, 1'b0};
        bit_cnt  <= '0;
        baud_cnt <= BIT_TC;
        active   <= 1'b1;
      end else if (active) begin
        if (baud_cnt == '0) begin
          baud_cnt <= BIT_TC;
          shreg    <= {1'b1, shreg[9:1]};
          if (bit_cnt == LAST_BIT) begin
            active  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/telemetry_tx.sv
// Telemetry frame transmitter: AA 55 LEN payload CSUM over 8N1 UART.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_IDLE    | no frame in flight, waiting for frame_start
//   ST_SYNC0   | first sync byte on the line
//   ST_SYNC1   | second sync byte on the line
//   ST_LEN     | length byte on the line
//   ST_PAYLOAD | payload byte idx on the line
//   ST_CSUM    | checksum byte on the line; frame ends with its stop bit
//
// Each state names the byte currently being serialised; the next byte is
// loaded on the stop-bit completion edge of the current one.
module telemetry_tx
  import telemetry_pkg::*;
#(
  parameter int         CLK_FREQ = 50000000,
  parameter int         BAUD     = 115200,
  parameter int         N_WORDS  = 4,
  parameter logic [7:0] SYNC0    = SYNC0_DEF,
  parameter logic [7:0] SYNC1    = SYNC1_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic [16*N_WORDS-1:0]  frame_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic [7:0]             drop_cnt,
  output logic                   TxD
);

  localparam int         DIV      = calc_div(CLK_FREQ, BAUD);
  localparam int         NB       = 2 * N_WORDS;
  localparam logic [7:0] LEN      = 8'(NB);
  localparam logic [4:0] LAST_IDX = 5'(NB - 1);

  tx_state_t              state, state_nxt;
  logic [16*N_WORDS-1:0]  snap;
  logic [4:0]             idx;
  logic [7:0]             csum, csum_nxt;
  logic                   load;
  logic [7:0]             tx_data;
  logic                   ready, byte_done;
  logic                   accept;

  // Byte k of the payload: word k/2, high byte first.
  function automatic logic [7:0] pick_byte(input logic [16*N_WORDS-1:0] words,
                                           input logic [4:0] k);
    logic [8:0]            base;
    logic [16*N_WORDS-1:0] sh;
    base = {1'b0, k[4:1], 4'b0000} + {5'b0, ~k[0], 3'b000};
    sh   = words >> base;
    return sh[7:0];
  endfunction

  // The serialiser is free in idle and again in the final stop-bit cycle,
  // which lets a new frame chain on without a gap.
  assign busy       = !(ready && (state == ST_IDLE || state == ST_CSUM));
  assign frame_done = (state == ST_CSUM) && byte_done;
  assign accept     = frame_start && !busy;

  uart_tx_byte #(.DIV(DIV)) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (tx_data),
    .load      (load),
    .TxD       (TxD),
    .ready     (ready),
    .byte_done (byte_done)
  );

  // Next-state, byte selection and running checksum.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    tx_data   = SYNC0;
    csum_nxt  = csum;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = ST_SYNC0;
        end
      end
      ST_SYNC0: begin
        if (byte_done) begin
          load      = 1'b1;
          tx_data   = SYNC1;
          state_nxt = ST_SYNC1;
        end
      end
      ST_SYNC1: begin
        if (byte_done) begin
          load      = 1'b1;
          tx_data   = LEN;
          csum_nxt  = LEN;
          state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_done) begin
          load      = 1'b1;
          tx_data   = pick_byte(snap, 5'd0);
          csum_nxt  = csum + tx_data;
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (byte_done) begin
          load = 1'b1;
          if (idx == LAST_IDX) begin
            tx_data   = csum;
            state_nxt = ST_CSUM;
          end else begin
            tx_data  = pick_byte(snap, idx + 5'd1);
            csum_nxt = csum + tx_data;
          end
        end
      end
      ST_CSUM: begin
        if (byte_done) begin
          state_nxt = ST_IDLE;
          if (accept) begin
            load      = 1'b1;
            state_nxt = ST_SYNC0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, payload snapshot, byte index and checksum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      snap  <= '0;
      idx   <= '0;
      csum  <= '0;
    end else begin
      state <= state_nxt;
      csum  <= csum_nxt;
      if (accept) snap <= frame_data;
      if (state == ST_LEN && byte_done) idx <= '0;
      else if (state == ST_PAYLOAD && byte_done) idx <= idx + 5'd1;
    end
  end

  // Saturating count of requests that arrive while a frame is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (frame_start && busy && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
